// File: rtl/vec_acc_requant_pkg.sv
// Shared types and constants for the partial-sum accumulator / int8 requantiser.
package vec_acc_requant_pkg;

    localparam int unsigned CFG_SCALE_WIDTH = 16;
    localparam int unsigned CFG_SHIFT_WIDTH = 5;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } acc_state_t;

    typedef struct packed {
        logic [CFG_SCALE_WIDTH-1:0] scale;
        logic [CFG_SHIFT_WIDTH-1:0] shift;
    } requant_cfg_t;

endpackage

// File: rtl/vec_acc_requant_result_fifo.sv
// Small synchronous FIFO for requantised results; storage is reset so the head reads 0 after reset.
module vec_acc_requant_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/vec_acc_requant.sv
// Accumulates N partial sums per element, requantises to int8 and buffers behind valid/ready.
// Optional macro VEC_ACC_RELU_EN clamps negative results to zero before saturation.
module vec_acc_requant
    import vec_acc_requant_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned SCALE_WIDTH = 16,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_psum_valid,
    input  logic signed [PSUM_WIDTH-1:0] i_psum,
    input  logic [CNT_WIDTH-1:0]         i_num_chunks,
    input  logic [SCALE_WIDTH-1:0]       i_scale,
    input  logic [4:0]                   i_shift,
    input  logic                         i_clr_err,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [OUT_WIDTH-1:0]         o_data,
    output logic                         o_busy,
    output logic [1:0]                   o_err
);

    localparam int unsigned PROD_WIDTH = PSUM_WIDTH + SCALE_WIDTH + 1;
    localparam logic signed [PSUM_WIDTH-1:0] ACC_MAX = {1'b0, {(PSUM_WIDTH - 1){1'b1}}};
    localparam logic signed [PSUM_WIDTH-1:0] ACC_MIN = {1'b1, {(PSUM_WIDTH - 1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]         CNT_ONE = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
    localparam logic signed [PROD_WIDTH-1:0] Q_MAX   = PROD_WIDTH'(INT8_MAX);
    localparam logic signed [PROD_WIDTH-1:0] Q_MIN   = PROD_WIDTH'(INT8_MIN);

    acc_state_t                    state;
    logic signed [PSUM_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]          cnt;
    logic [CNT_WIDTH-1:0]          grp_n;
    requant_cfg_t                  grp_cfg;
    requant_cfg_t                  in_cfg;
    logic [CNT_WIDTH-1:0]          in_n;

    logic signed [PSUM_WIDTH:0]    raw_sum;
    logic                          sat_hi;
    logic                          sat_lo;
    logic signed [PSUM_WIDTH-1:0]  sat_sum;
    logic                          last_chunk;
    logic                          finish;
    logic signed [PSUM_WIDTH-1:0]  fin_sum;
    requant_cfg_t                  fin_cfg;
    logic                          acc_ovf;

    logic                          s0_valid;
    logic signed [PSUM_WIDTH-1:0]  s0_sum;
    requant_cfg_t                  s0_cfg;
    logic                          s1_valid;
    logic signed [PROD_WIDTH-1:0]  s1_prod;
    logic [4:0]                    s1_shift;

    logic signed [PROD_WIDTH-1:0]  rnd;
    logic signed [PROD_WIDTH-1:0]  rounded;
    logic signed [PROD_WIDTH-1:0]  shifted;
    logic [OUT_WIDTH-1:0]          q_data;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          pop;
    logic                          drop;

    assign in_cfg  = '{scale: i_scale, shift: i_shift};
    assign in_n    = (i_num_chunks == '0) ? CNT_ONE : i_num_chunks;

    assign raw_sum = {acc[PSUM_WIDTH-1], acc} + {i_psum[PSUM_WIDTH-1], i_psum};
    assign sat_hi  = !raw_sum[PSUM_WIDTH] && raw_sum[PSUM_WIDTH-1];
    assign sat_lo  = raw_sum[PSUM_WIDTH] && !raw_sum[PSUM_WIDTH-1];
    assign sat_sum = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : raw_sum[PSUM_WIDTH-1:0]);

    assign last_chunk = (({1'b0, cnt} + {1'b0, CNT_ONE}) == {1'b0, grp_n});
    assign finish     = i_psum_valid && ((state == ST_IDLE) ? (in_n == CNT_ONE) : last_chunk);
    assign fin_sum    = (state == ST_IDLE) ? i_psum : sat_sum;
    assign fin_cfg    = (state == ST_IDLE) ? in_cfg : grp_cfg;
    assign acc_ovf    = i_psum_valid && (state == ST_ACCUM) && (sat_hi || sat_lo);
    assign o_busy     = (state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= finish;
            if (i_psum_valid) begin
                unique case (state)
                    ST_IDLE: begin
                        cnt <= CNT_ONE;
                        if (!finish) state <= ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        cnt <= cnt + CNT_ONE;
                        if (finish) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_psum_valid) begin
            if (state == ST_IDLE) begin
                acc     <= i_psum;
                grp_n   <= in_n;
                grp_cfg <= in_cfg;
            end else begin
                acc <= sat_sum;
            end
        end
        if (finish) begin
            s0_sum <= fin_sum;
            s0_cfg <= fin_cfg;
        end
        // Scale is zero-extended so the product stays a signed-by-unsigned multiply.
        s1_prod  <= signed'(PROD_WIDTH'(s0_sum)) * signed'(PROD_WIDTH'(s0_cfg.scale));
        s1_shift <= s0_cfg.shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
        end
    end

    always_comb begin
        rnd     = (s1_shift == 5'd0) ? '0 : (PROD_WIDTH'(1) << (s1_shift - 5'd1));
        rounded = s1_prod + rnd;
        shifted = rounded >>> s1_shift;
`ifdef VEC_ACC_RELU_EN
        if (shifted < 0) shifted = '0;
`endif
        if (shifted > Q_MAX) begin
            q_data = OUT_WIDTH'(INT8_MAX);
        end else if (shifted < Q_MIN) begin
            q_data = OUT_WIDTH'(INT8_MIN);
        end else begin
            q_data = shifted[OUT_WIDTH-1:0];
        end
    end

    assign o_valid = !fifo_empty;
    assign pop     = o_valid && i_ready;
    assign drop    = s1_valid && fifo_full && !pop;

    vec_acc_requant_result_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .wdata (q_data),
        .pop   (pop),
        .rdata (o_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 2'b00;
        end else begin
            o_err <= (i_clr_err ? 2'b00 : o_err) | {acc_ovf, drop};
        end
    end

endmodule
